// File: rtl/fpu_req_arbiter_if.sv
// Bundle of signals between the FPU arbiter, its requesters, the response
// consumer and the shared FPU. The arbiter takes the master view; the
// environment (requesters, consumer, FPU) takes the slave view.
interface fpu_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // Requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_op_a;
  logic [32*NUM_REQ-1:0] req_op_b;
  // Response side
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic [3:0]            resp_status;
  // FPU side
  logic [31:0]           fpu_op_a;
  logic [31:0]           fpu_op_b;
  logic [31:0]           fpu_data_in;
  logic [3:0]            fpu_status_in;

  modport master (
    input  req_valid, req_op_a, req_op_b, resp_ready, fpu_data_in, fpu_status_in,
    output req_ready, resp_valid, resp_id, resp_data, resp_status, fpu_op_a, fpu_op_b
  );

  modport slave (
    output req_valid, req_op_a, req_op_b, resp_ready, fpu_data_in, fpu_status_in,
    input  req_ready, resp_valid, resp_id, resp_data, resp_status, fpu_op_a, fpu_op_b
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing a single fixed-latency FPU between NUM_REQ
// requesters. Operands of the winner are held on the FPU inputs for
// FPU_LATENCY cycles, the result is captured and returned on a valid/ready
// response port tagged with the winner's index.
module fpu_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FPU_LATENCY = 8,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  fpu_req_arbiter_if.master    bus,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [3:0]      resp_status_q, resp_status_d;

  // Request vector rotated so that bit 0 corresponds to rr_ptr.
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      grant_next;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [31:0]          sel_op_a;
  logic [31:0]          sel_op_b;

  assign valid_dbl = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
  assign valid_rot = valid_dbl[NUM_REQ-1:0];

  // Find the first valid requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_found = 1'b1;
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  // Pointer after the current grant, wrapping at NUM_REQ (not 2^ID_W).
  always_comb begin
    logic [ID_W:0] inc;
    inc = {1'b0, grant_idx} + 1'b1;
    if (inc >= (ID_W+1)'(NUM_REQ)) begin
      inc = '0;
    end
    grant_next = inc[ID_W-1:0];
  end

  // One-hot grant and operand selection per requester slot.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_found && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Multiplex the winner's operands onto the capture path.
  always_comb begin
    sel_op_a = '0;
    sel_op_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_onehot[k]) begin
        sel_op_a = bus.req_op_a[32*k +: 32];
        sel_op_b = bus.req_op_b[32*k +: 32];
      end
    end
  end

  // Next-state and datapath update for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    cnt_d         = cnt_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_a_d     = sel_op_a;
          op_b_d     = sel_op_b;
          grant_id_d = grant_idx;
          rr_ptr_d   = grant_next;
          cnt_d      = 8'(FPU_LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          resp_data_d   = bus.fpu_data_in;
          resp_status_d = bus.fpu_status_in;
          resp_id_d     = grant_id_q;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      cnt_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      cnt_q         <= cnt_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE && !reset) ? grant_onehot : '0;
  assign bus.fpu_op_a    = op_a_q;
  assign bus.fpu_op_b    = op_b_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_status = resp_status_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: one instance with FPU_LATENCY=8 and
// one with FPU_LATENCY=1, each driven by an XOR stub FPU.
module tb_fpu_req_arbiter;

  logic clock;
  logic reset;
  logic busy_a;
  logic busy_b;

  int n_vec = 0;
  int n_err = 0;

  fpu_req_arbiter_if #(.NUM_REQ(2)) a_if ();
  fpu_req_arbiter_if #(.NUM_REQ(2)) b_if ();

  fpu_req_arbiter #(.NUM_REQ(2), .FPU_LATENCY(8)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if.master),
    .busy  (busy_a)
  );

  fpu_req_arbiter #(.NUM_REQ(2), .FPU_LATENCY(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if.master),
    .busy  (busy_b)
  );

  // Stub FPUs: data = op_a ^ op_b, status = 1, combinational.
  assign a_if.fpu_data_in   = a_if.fpu_op_a ^ a_if.fpu_op_b;
  assign a_if.fpu_status_in = 4'h1;
  assign b_if.fpu_data_in   = b_if.fpu_op_a ^ b_if.fpu_op_b;
  assign b_if.fpu_status_in = 4'h1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc_last;
    int grants;
    int exp_id;
    int pend_id;
    logic [31:0] pend_data;
    logic [31:0] hold_data;
    int seen;
    int found;

    reset = 1'b1;
    a_if.req_valid = 2'b11; a_if.resp_ready = 1'b0;
    a_if.req_op_a = {32'h12345678, 32'h3E000000};
    a_if.req_op_b = {32'h0F0F0F0F, 32'h40000000};
    b_if.req_valid = 2'b00; b_if.resp_ready = 1'b0;
    b_if.req_op_a = {32'h12345678, 32'h3E000000};
    b_if.req_op_b = {32'h0F0F0F0F, 32'h40000000};
    tick(); tick();

    // Reset state (requests asserted during reset must not be granted)
    chk("rst_req_ready", 32'(a_if.req_ready), 32'h0);
    chk("rst_busy",      32'(busy_a),         32'h0);
    chk("rst_resp_valid",32'(a_if.resp_valid),32'h0);
    chk("rst_resp_id",   32'(a_if.resp_id),   32'h0);
    chk("rst_resp_data", a_if.resp_data,      32'h0);
    chk("rst_resp_stat", 32'(a_if.resp_status),32'h0);
    chk("rst_fpu_op_a",  a_if.fpu_op_a,       32'h0);
    chk("rst_fpu_op_b",  a_if.fpu_op_b,       32'h0);

    a_if.req_valid = 2'b00;
    reset = 1'b0;
    tick();

    // Single request from requester 0
    a_if.req_valid = 2'b01;
    #1;
    chk("single_req_ready", 32'(a_if.req_ready), 32'h1);
    tick();                                   // handshake edge E0
    a_if.req_valid = 2'b00;
    chk("single_op_a", a_if.fpu_op_a, 32'h3E000000);
    chk("single_op_b", a_if.fpu_op_b, 32'h40000000);
    chk("single_busy", 32'(busy_a), 32'h1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("single_wait_c%0d", i), 32'(a_if.resp_valid), 32'h0);
    end
    tick();                                   // 8 cycles after E0
    chk("single_resp_valid",  32'(a_if.resp_valid), 32'h1);
    chk("single_resp_data",   a_if.resp_data, 32'h7E000000);
    chk("single_resp_status", 32'(a_if.resp_status), 32'h1);
    chk("single_resp_id",     32'(a_if.resp_id), 32'h0);

    // Backpressure: hold resp_ready low with both requesters pending
    a_if.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_valid_c%0d", i), 32'(a_if.resp_valid), 32'h1);
      chk($sformatf("bp_data_c%0d", i),  a_if.resp_data, 32'h7E000000);
      chk($sformatf("bp_id_c%0d", i),    32'(a_if.resp_id), 32'h0);
      chk($sformatf("bp_busy_c%0d", i),  32'(busy_a), 32'h1);
      chk($sformatf("bp_ready_c%0d", i), 32'(a_if.req_ready), 32'h0);
    end
    a_if.resp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(a_if.resp_valid), 32'h0);
    chk("bp_release_busy",  32'(busy_a), 32'h0);

    // Fairness: both valid, resp_ready high; grants alternate from 1
    grants = 0; exp_id = 1; cyc_last = 0; pend_id = 0; pend_data = 32'h0; seen = 0;
    for (int c = 0; c < 80 && grants < 4; c++) begin
      if (a_if.resp_valid) begin
        chk($sformatf("rr_resp_id_g%0d", grants), 32'(a_if.resp_id), 32'(pend_id));
        chk($sformatf("rr_resp_data_g%0d", grants), a_if.resp_data, pend_data);
        seen++;
      end
      if (a_if.req_ready != 2'b00) begin
        chk($sformatf("rr_onehot_g%0d", grants), 32'(a_if.req_ready),
            (exp_id == 1) ? 32'h2 : 32'h1);
        if (grants > 0) chk($sformatf("rr_interval_g%0d", grants), 32'(c - cyc_last), 32'd10);
        cyc_last  = c;
        pend_id   = exp_id;
        pend_data = (exp_id == 1) ? 32'h1D3B5977 : 32'h7E000000;
        exp_id    = 1 - exp_id;
        grants++;
      end
      tick();
    end
    chk("rr_grant_count", 32'(grants), 32'd4);
    chk("rr_resp_count",  32'(seen),   32'd3);

    // Round-robin skip: only requester 0 valid after a grant to 0
    a_if.req_valid = 2'b01;
    seen = 0; found = 0;
    for (int c = 0; c < 30; c++) begin
      if (a_if.resp_valid) begin
        chk("skip_resp_id",   32'(a_if.resp_id), 32'h0);
        chk("skip_resp_data", a_if.resp_data, 32'h7E000000);
        seen++;
      end
      if (a_if.req_ready != 2'b00) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("skip_resp_seen", 32'(seen), 32'd1);
    chk("skip_granted",   32'(found), 32'd1);
    chk("skip_ready",     32'(a_if.req_ready), 32'h1);
    tick();                                   // handshake edge E0
    a_if.req_valid = 2'b00;
    chk("skip_busy", 32'(busy_a), 32'h1);

    // Reset three cycles after the handshake
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("abort_resp_valid", 32'(a_if.resp_valid), 32'h0);
    chk("abort_busy",       32'(busy_a), 32'h0);
    chk("abort_fpu_op_a",   a_if.fpu_op_a, 32'h0);
    reset = 1'b0;
    tick();
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_if.resp_valid) seen++;
      tick();
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    a_if.req_valid = 2'b11;                   // rr_ptr back at 0 -> grant 0
    #1;
    chk("abort_rr_ptr0", 32'(a_if.req_ready), 32'h1);
    a_if.req_valid = 2'b00;

    // FPU_LATENCY=1 instance
    b_if.req_valid = 2'b10;
    #1;
    chk("lat1_ready", 32'(b_if.req_ready), 32'h2);
    tick();                                   // handshake edge E0
    b_if.req_valid = 2'b00;
    chk("lat1_wait_valid", 32'(b_if.resp_valid), 32'h0);
    chk("lat1_fpu_data",   b_if.fpu_data_in, 32'h1D3B5977);
    tick();
    chk("lat1_resp_valid", 32'(b_if.resp_valid), 32'h1);
    chk("lat1_resp_data",  b_if.resp_data, 32'h1D3B5977);
    chk("lat1_resp_id",    32'(b_if.resp_id), 32'h1);
    hold_data = b_if.resp_data;
    b_if.resp_ready = 1'b1;
    tick();
    chk("lat1_release", 32'(b_if.resp_valid), 32'h0);
    chk("lat1_busy",    32'(busy_b), 32'h0);
    chk("lat1_hold_op", b_if.fpu_op_a ^ b_if.fpu_op_b, hold_data);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_req_arbiter.md
Name: fpu_req_arbiter

Overview:
- Shares one FPU instance between NUM_REQ requesters; all requesters and the FPU live on the same clock.
- Round-robin arbitration of operand requests.
- Drives the FPU operand buses and holds them stable for FPU_LATENCY cycles.
- Captures the result and status, then returns them to the winning requester through a valid/ready response port tagged with the requester ID.
- Operands use the 32-bit format: 1 sign bit, 6-bit exponent with bias 31, 25-bit mantissa.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- FPU_LATENCY, 8: cycles the operands are held before the result is sampled; legal range 1..255.
- ID_W, $clog2(NUM_REQ): width of the requester ID.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_op_a  in  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_op_b  in  32*NUM_REQ  operand B; same packing as req_op_a.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  32  captured FPU data_out.
- resp_status  out  4  captured FPU status_out.
- fpu_op_a  out  32  connects to FPU op_A_in.
- fpu_op_b  out  32  connects to FPU op_B_in.
- fpu_data_in  in  32  connects to FPU data_out.
- fpu_status_in  in  4  connects to FPU status_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - fpu_op_a=fpu_op_b=0, resp_valid=0, resp_id=0, resp_data=0, resp_status=0.
  - busy=0; req_ready=0 in the cycle reset is high.
  - A reset mid-operation aborts the in-flight request: no response is issued and the requester must re-request.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - Grant is combinational: the first asserted req_valid searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is asserted only for the granted index, and only in IDLE.
  - Handshake occurs at edge E0 when req_valid[g] and req_ready[g] are both high. At E0:
    - fpu_op_a/b <= req_op_a/b of g.
    - grant_id <= g.
    - rr_ptr <= (g+1) mod NUM_REQ.
    - counter <= FPU_LATENCY-1.
    - state -> WAIT.
  - With no req_valid: stay in IDLE; rr_ptr is unchanged.
- WAIT:
  - fpu_op_a/b are held constant.
  - The counter decrements each cycle.
  - At the edge where counter==0: resp_data <= fpu_data_in, resp_status <= fpu_status_in, resp_id <= grant_id, resp_valid <= 1, state -> RESP.
  - resp_valid is therefore first high exactly FPU_LATENCY cycles after the E0 handshake cycle.
- RESP:
  - resp_valid, resp_id, resp_data and resp_status are held stable until resp_ready.
  - On the resp_valid && resp_ready edge: resp_valid <= 0, state -> IDLE.
  - resp_ready asserted early has no effect until resp_valid is high.
- Throughput:
  - Minimum interval between accepted requests is FPU_LATENCY+2 cycles.
  - requests arriving while busy are not dropped; requesters hold req_valid.
- After capture, fpu_op_a/b retain their last values until the next grant.
- A requester dropping req_valid before it is granted is legal; that requester is simply skipped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- The ID and rr_ptr wrap at NUM_REQ, not at 2^ID_W.

Test Plan:
- Stub FPU used in all scenarios: data = op_a ^ op_b, status = 4'h1, combinational.
- Single request, NUM_REQ=2, FPU_LATENCY=8: req 0 with A=0x3E000000 (1.0), B=0x40000000 (2.0) -> req_ready[0] same cycle; fpu_op_a=0x3E000000 from the next cycle; resp_valid 8 cycles after the handshake with resp_data=0x7E000000, resp_status=4'h1, resp_id=0.
- Both requesters valid continuously, resp_ready=1: grants go 0,1,0,1. Each req_ready is one-hot, and accepted requests are 10 cycles apart.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> response fields stay stable, busy=1, and req_ready stays 0 throughout. Raising resp_ready returns the FSM to IDLE on the next edge.
- Round-robin skip: after a grant to 0, only req 0 is valid -> req 0 is granted again; rr_ptr wraps and there is no deadlock.
- Reset mid-WAIT: assert reset 3 cycles after a handshake -> next cycle resp_valid=0, busy=0, fpu_op_a=0, rr_ptr=0, and no response is ever produced for the aborted request.
- FPU_LATENCY=1: verify resp_valid one cycle after the handshake and capture of fpu_data_in from that exact cycle.
